mem_access_unit: RTL

Pipeline stage between execute and load writeback. Latches one instruction per slot with its effective address and store data. Runs a data-memory request/grant/response transaction for loads and stores, then presents the instruction, its branch tag and any load data to the writeback stage. Non-memory instructions pass through in one cycle. The stage stalls upstream while a memory access is outstanding or while downstream stalls.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/pipeline_unit.sv | 26 ++
 rtl/mem_access_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the execute -> memory -> writeback pipeline units.
//   NOP_INSTR    : encoding written into a slot that carries no instruction.
//   mem_state_t  : state encoding of the memory access stage FSM.
//   is_load()    : opcode classifier for loads (shared with writeback decode).
//   is_store()   : opcode classifier for stores.
// -----------------------------------------------------------------------------
package pipeline_pkg;

   localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } mem_state_t;

   function automatic logic is_load(input logic [6:0] opcode);
      return (opcode[6:4] == 3'b110) || (opcode[6:3] == 4'b1000);
   endfunction

   function automatic logic is_store(input logic [6:0] opcode);
      return (opcode[6:4] == 3'b111) || (opcode[6:3] == 4'b1001);
   endfunction

endpackage

// File: rtl/pipeline_unit.sv
// -----------------------------------------------------------------------------
// pipeline_unit
// Instruction decoder shared by the pipeline stages. Extracts the opcode field
// and classifies the instruction as a load or a store.
//   instr  : in  32  raw instruction word
//   is_ld  : out 1   instruction is a load
//   is_st  : out 1   instruction is a store
// -----------------------------------------------------------------------------
module pipeline_unit
   import pipeline_pkg::*;
(
   input  logic [31:0] instr,
   output logic        is_ld,
   output logic        is_st
);

   logic [6:0] opcode;
   // Only the opcode field matters for memory classification.
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign unused_fields = ^instr[31:7];
   assign is_ld         = is_load(opcode);
   assign is_st         = is_store(opcode);

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Pipeline stage between execute and load writeback. Holds one instruction,
// runs a request/grant/response data-memory access for loads and stores, and
// presents the instruction, its branch tag and load data to writeback.
//
// Handshake: upstream transfers an instruction on a rising edge where
// valid_in && ready_out; downstream consumes the output slot on a rising edge
// where the stage is in OUT and stall_in is low. Memory: a request is
// transferred on an edge where mem_req && mem_gnt; the response is taken on
// the first edge with mem_rvalid after (or together with) the grant.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_in, valid_in       instruction from execute and its valid
//   ready_out                stage can accept an instruction this cycle
//   branch_in, branch_ref    tag of instr_in, current branch tag
//   addr_in, wdata_in        effective address and store data
//   mem_req/we/addr/wdata    data-memory request
//   mem_gnt, mem_rvalid,
//   mem_rdata                grant, response valid, load data
//   instr_out, branch_value,
//   valid_out, ldr_data_out  writeback slot
//   stall_in                 writeback cannot accept, hold the slot
//   mem_err                  one-cycle pulse when an access times out
//   state_dbg                current FSM state
// -----------------------------------------------------------------------------
module mem_access_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_in,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic        branch_in,
   input  logic        branch_ref,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr_out,
   output logic        branch_value,
   output logic        valid_out,
   output logic [31:0] ldr_data_out,
   input  logic        stall_in,
   output logic        mem_err,
   output mem_state_t  state_dbg
);

   // The counter is 8 bits wide, so larger limits behave as 255.
   localparam logic [7:0] TIMEOUT_CNT = (TIMEOUT > 255) ? 8'hFF : 8'(TIMEOUT);

   mem_state_t  state_q, state_d;
   logic [31:0] slot_instr_q, slot_instr_d;
   logic        slot_tag_q, slot_tag_d;
   logic        slot_ld_q, slot_ld_d;
   logic        slot_bubble_q, slot_bubble_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] instr_out_q, instr_out_d;
   logic        branch_value_q, branch_value_d;
   logic        valid_out_q, valid_out_d;
   logic [31:0] ldr_data_q, ldr_data_d;
   logic        mem_err_q, mem_err_d;
   logic [7:0]  tcnt_q, tcnt_d;

   logic        in_ld, in_st, in_bubble, in_mem;
   logic        slot_squash;
   logic [7:0]  tcnt_inc;
   logic        accept, present, present_bubble;
   logic        unused_addr_lsb;

   pipeline_unit u_decode (
      .instr (instr_in),
      .is_ld (in_ld),
      .is_st (in_st)
   );

   assign unused_addr_lsb = ^addr_in[1:0];

   // An instruction arriving with a stale tag becomes a bubble immediately and
   // never reaches memory.
   assign in_bubble   = (branch_in != branch_ref);
   assign in_mem      = (in_ld | in_st) & ~in_bubble;
   assign slot_squash = (slot_tag_q != branch_ref);
   assign tcnt_inc    = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;

   always_comb begin
      state_d        = state_q;
      slot_instr_d   = slot_instr_q;
      slot_tag_d     = slot_tag_q;
      slot_ld_d      = slot_ld_q;
      slot_bubble_d  = slot_bubble_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      instr_out_d    = instr_out_q;
      branch_value_d = branch_value_q;
      valid_out_d    = valid_out_q;
      ldr_data_d     = ldr_data_q;
      mem_err_d      = 1'b0;
      tcnt_d         = tcnt_q;
      accept         = 1'b0;
      present        = 1'b0;
      present_bubble = 1'b0;

      case (state_q)
         IDLE: accept = valid_in;

         REQ: begin
            if (slot_squash) begin
               // Request is withdrawn combinationally this cycle (see mem_req).
               present        = 1'b1;
               present_bubble = 1'b1;
               state_d        = OUT;
            end else if (mem_gnt && mem_rvalid) begin
               present        = 1'b1;
               present_bubble = slot_bubble_q;
               state_d        = OUT;
            end else if (mem_gnt) begin
               tcnt_d  = '0;
               state_d = WAIT;
            end
         end

         WAIT: begin
            tcnt_d = tcnt_inc;
            if (mem_rvalid) begin
               // A granted access must still drain; a squash only discards it.
               present        = 1'b1;
               present_bubble = slot_bubble_q | slot_squash;
               state_d        = OUT;
            end else if (tcnt_inc >= TIMEOUT_CNT) begin
               present        = 1'b1;
               present_bubble = 1'b1;
               mem_err_d      = 1'b1;
               state_d        = OUT;
            end else if (slot_squash) begin
               slot_bubble_d = 1'b1;
            end
         end

         OUT: begin
            if (slot_squash) begin
               slot_bubble_d = 1'b1;
               instr_out_d   = NOP_INSTR;
               valid_out_d   = 1'b0;
               ldr_data_d    = '0;
            end
            if (!stall_in) begin
               if (valid_in) begin
                  accept = 1'b1;
               end else begin
                  state_d     = IDLE;
                  instr_out_d = NOP_INSTR;
                  valid_out_d = 1'b0;
                  ldr_data_d  = '0;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // Load the writeback slot from the finished memory access.
      if (present) begin
         slot_bubble_d  = present_bubble;
         instr_out_d    = present_bubble ? NOP_INSTR : slot_instr_q;
         valid_out_d    = ~present_bubble;
         ldr_data_d     = (slot_ld_q && !present_bubble) ? mem_rdata : '0;
         branch_value_d = slot_tag_q;
      end

      // Accept a new instruction (from IDLE, or directly out of a consumed OUT).
      if (accept) begin
         slot_instr_d  = instr_in;
         slot_tag_d    = branch_in;
         slot_ld_d     = in_ld;
         slot_bubble_d = in_bubble;
         if (in_mem) begin
            mem_we_d    = in_st;
            mem_addr_d  = {addr_in[31:2], 2'b00};
            mem_wdata_d = wdata_in;
            instr_out_d = NOP_INSTR;
            valid_out_d = 1'b0;
            ldr_data_d  = '0;
            state_d     = REQ;
         end else begin
            instr_out_d    = in_bubble ? NOP_INSTR : instr_in;
            valid_out_d    = ~in_bubble;
            ldr_data_d     = '0;
            branch_value_d = branch_in;
            state_d        = OUT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         slot_instr_q   <= NOP_INSTR;
         slot_tag_q     <= 1'b0;
         slot_ld_q      <= 1'b0;
         slot_bubble_q  <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         instr_out_q    <= NOP_INSTR;
         branch_value_q <= 1'b0;
         valid_out_q    <= 1'b0;
         ldr_data_q     <= '0;
         mem_err_q      <= 1'b0;
         tcnt_q         <= '0;
      end else begin
         state_q        <= state_d;
         slot_instr_q   <= slot_instr_d;
         slot_tag_q     <= slot_tag_d;
         slot_ld_q      <= slot_ld_d;
         slot_bubble_q  <= slot_bubble_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         instr_out_q    <= instr_out_d;
         branch_value_q <= branch_value_d;
         valid_out_q    <= valid_out_d;
         ldr_data_q     <= ldr_data_d;
         mem_err_q      <= mem_err_d;
         tcnt_q         <= tcnt_d;
      end
   end

   assign ready_out    = (state_q == IDLE) || ((state_q == OUT) && !stall_in);
   assign mem_req      = (state_q == REQ) && !slot_squash;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign instr_out    = instr_out_q;
   assign branch_value = branch_value_q;
   assign valid_out    = valid_out_q;
   assign ldr_data_out = ldr_data_q;
   assign mem_err      = mem_err_q;
   assign state_dbg    = state_q;

endmodule
